// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: ALU results win,
// load results queue in a small FIFO, and a scoreboard tracks pending destinations.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  input  logic                     iss_valid,
  input  logic [4:0]               iss_rd,
  input  logic [4:0]               ReadAddr1,
  input  logic [4:0]               ReadAddr2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     RegWrite,
  output logic [4:0]               WriteAddr,
  output logic [XLEN-1:0]          WriteData,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]      rdMem   [DEPTH];
  logic [XLEN-1:0] dataMem [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]   count;
  logic            fifoEmpty, fifoFull, push, pop;
  logic            sel;
  logic [4:0]      selRd;
  logic [XLEN-1:0] selData;
  logic [31:0]     busy, busyNext;

  assign fifoEmpty  = (count == '0);
  assign fifoFull   = (count == FULL_CNT);
  assign ld_ready   = !fifoFull;
  assign push       = ld_valid && !fifoFull;
  assign pop        = !alu_valid && !fifoEmpty;
  assign fifo_count = count;

  // Fixed priority: the ALU cannot stall, so the FIFO head only goes when it is idle.
  assign sel     = alu_valid || !fifoEmpty;
  assign selRd   = alu_valid ? alu_rd   : rdMem[rdPtr];
  assign selData = alu_valid ? alu_data : dataMem[rdPtr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rdMem[wrPtr]   <= ld_rd;
      dataMem[wrPtr] <= ld_data;
    end
  end

  // Write-port register stage; x0 results are consumed without a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= sel && (selRd != 5'd0);
      if (sel) begin
        WriteAddr <= selRd;
        WriteData <= selData;
      end
    end
  end

  // Set is applied after clear so a same-edge reissue keeps the register pending.
  always_comb begin
    busyNext = busy;
    if (RegWrite)  busyNext[WriteAddr] = 1'b0;
    if (iss_valid) busyNext[iss_rd]    = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busyNext;
  end

  assign busy1 = busy[ReadAddr1];
  assign busy2 = busy[ReadAddr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              alu_valid = 1'b0;
  logic [4:0]        alu_rd = '0;
  logic [XLEN-1:0]   alu_data = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [4:0]        ld_rd = '0;
  logic [XLEN-1:0]   ld_data = '0;
  logic              iss_valid = 1'b0;
  logic [4:0]        iss_rd = '0;
  logic [4:0]        ReadAddr1 = '0;
  logic [4:0]        ReadAddr2 = '0;
  logic              busy1, busy2;
  logic              RegWrite;
  logic [4:0]        WriteAddr;
  logic [XLEN-1:0]   WriteData;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int failures = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .busy1(busy1), .busy2(busy2),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results as a queue, pending registers as a bit set.
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] d;
  } ent_t;

  ent_t            mq[$];
  bit [31:0]       mBusy = '0;
  bit              mRegWrite = 1'b0;
  logic [4:0]      mAddr = '0;
  logic [XLEN-1:0] mData = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mBusy     = '0;
      mRegWrite = 1'b0;
      mAddr     = '0;
      mData     = '0;
    end else begin
      bit         canAccept;
      bit         got;
      ent_t       e;
      canAccept = (mq.size() < DEPTH);
      got = 1'b0;
      if (alu_valid) begin
        e.rd = alu_rd; e.d = alu_data; got = 1'b1;
      end else if (mq.size() > 0) begin
        e = mq.pop_front(); got = 1'b1;
      end
      if (ld_valid && canAccept) begin
        ent_t n;
        n.rd = ld_rd; n.d = ld_data;
        mq.push_back(n);
      end
      if (mRegWrite) mBusy[mAddr] = 1'b0;
      if (iss_valid && iss_rd != 0) mBusy[iss_rd] = 1'b1;
      mRegWrite = got && (e.rd != 0);
      if (got) begin
        mAddr = e.rd;
        mData = e.d;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("model_fifo_count", 64'(fifo_count), 64'(mq.size()));
      chk("model_ld_ready",   64'(ld_ready),   64'(mq.size() < DEPTH));
      chk("model_RegWrite",   64'(RegWrite),   64'(mRegWrite));
      if (mRegWrite) begin
        chk("model_WriteAddr", 64'(WriteAddr), 64'(mAddr));
        chk("model_WriteData", 64'(WriteData), 64'(mData));
      end
      chk("model_busy1", 64'(busy1), 64'(ReadAddr1 != 0 && mBusy[ReadAddr1]));
      chk("model_busy2", 64'(busy2), 64'(ReadAddr2 != 0 && mBusy[ReadAddr2]));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("reset_RegWrite", 64'(RegWrite), 64'd0);
    chk("reset_fifo_count", 64'(fifo_count), 64'd0);
    chk("reset_ld_ready", 64'(ld_ready), 64'd1);
    cyc(); cyc();
    rst = 1'b1;

    // ALU write and scoreboard clear
    cyc(); iss_valid = 1'b1; iss_rd = 5'd5; ReadAddr1 = 5'd5;
    cyc(); iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1 chk("alu_busy_before", 64'(busy1), 64'd1);
    cyc(); alu_valid = 1'b0;
    #1;
    chk("alu_RegWrite", 64'(RegWrite), 64'd1);
    chk("alu_WriteAddr", 64'(WriteAddr), 64'd5);
    chk("alu_WriteData", 64'(WriteData), 64'h1234);
    chk("alu_busy_at_write", 64'(busy1), 64'd1);
    cyc(); #1;
    chk("alu_busy_after", 64'(busy1), 64'd0);
    chk("alu_RegWrite_drop", 64'(RegWrite), 64'd0);

    // Load queued behind three ALU writes
    cyc(); alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd1;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hAA;
    cyc(); ld_valid = 1'b0; alu_rd = 5'd2; alu_data = 32'd2;
    #1 chk("lba_w1", 64'(WriteAddr), 64'd1);
    chk("lba_count", 64'(fifo_count), 64'd1);
    cyc(); alu_rd = 5'd3; alu_data = 32'd3;
    #1 chk("lba_w2", 64'(WriteAddr), 64'd2);
    cyc(); alu_valid = 1'b0;
    #1 chk("lba_w3", 64'(WriteAddr), 64'd3);
    cyc(); #1;
    chk("lba_load_RegWrite", 64'(RegWrite), 64'd1);
    chk("lba_load_addr", 64'(WriteAddr), 64'd7);
    chk("lba_load_data", 64'(WriteData), 64'hAA);
    chk("lba_drained", 64'(fifo_count), 64'd0);

    // FIFO full under continuous ALU traffic
    for (int i = 0; i < 5; i++) begin
      cyc(); alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'(i);
      ld_valid = 1'b1; ld_rd = 5'(20 + i); ld_data = 32'h100 + 32'(i);
      #1 chk("full_ld_ready", 64'(ld_ready), 64'(i < 4));
    end
    cyc(); alu_valid = 1'b0;
    #1 chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_not_ready", 64'(ld_ready), 64'd0);
    cyc(); #1;
    chk("drain_20", 64'(WriteAddr), 64'd20);
    chk("drain_count3", 64'(fifo_count), 64'd3);
    chk("drain_ready", 64'(ld_ready), 64'd1);
    cyc(); ld_valid = 1'b0;
    #1 chk("drain_21", 64'(WriteAddr), 64'd21);
    chk("drain_count_pushpop", 64'(fifo_count), 64'd3);
    cyc(); #1 chk("drain_22", 64'(WriteAddr), 64'd22);
    cyc(); #1 chk("drain_23", 64'(WriteAddr), 64'd23);
    cyc(); #1;
    chk("drain_24", 64'(WriteAddr), 64'd24);
    chk("drain_24_data", 64'(WriteData), 64'h104);
    chk("drain_empty", 64'(fifo_count), 64'd0);

    // x0 results are consumed silently
    cyc(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'd5;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'd6; ReadAddr1 = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd0;
    cyc(); idle();
    #1 chk("x0_alu_nowrite", 64'(RegWrite), 64'd0);
    chk("x0_count", 64'(fifo_count), 64'd1);
    cyc(); #1;
    chk("x0_ld_nowrite", 64'(RegWrite), 64'd0);
    chk("x0_popped", 64'(fifo_count), 64'd0);
    chk("x0_busy", 64'(busy1), 64'd0);

    // Same-edge set and clear on r9
    cyc(); iss_valid = 1'b1; iss_rd = 5'd9; ReadAddr2 = 5'd9;
    cyc(); iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    cyc(); alu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9;
    #1 chk("coll_write9", 64'(WriteAddr), 64'd9);
    cyc(); iss_valid = 1'b0;
    #1 chk("coll_busy9", 64'(busy2), 64'd1);
    cyc(); #1 chk("coll_busy9_cleared_later", 64'(busy2), 64'd1);

    // Asynchronous reset with three loads queued
    cyc(); iss_valid = 1'b1; iss_rd = 5'd12; ReadAddr1 = 5'd12;
    for (int i = 0; i < 3; i++) begin
      cyc(); iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'(i);
      ld_valid = 1'b1; ld_rd = 5'(11 + i); ld_data = 32'h200 + 32'(i);
    end
    cyc(); ld_valid = 1'b0;
    #1 chk("rst_pre_count", 64'(fifo_count), 64'd3);
    chk("rst_pre_busy", 64'(busy1), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_RegWrite", 64'(RegWrite), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_busy2", 64'(busy2), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    idle();
    cyc(); cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1 chk("rst_no_stale", 64'(RegWrite), 64'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      alu_valid = ($urandom_range(0, 99) < 45);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 99) < 55);
      ld_rd     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      iss_valid = ($urandom_range(0, 99) < 40);
      iss_rd    = 5'($urandom_range(0, 7));
      ReadAddr1 = 5'($urandom_range(0, 7));
      ReadAddr2 = 5'($urandom_range(0, 31));
      if (n == 1500) begin
        #1 rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
      end
    end
    idle();
    for (int i = 0; i < 10; i++) cyc();
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
